// File: rtl/maquina_pkg.sv
// Shared types for the drink dispenser: drink codes, display phases, recipe table
// and the phase-ordering helpers used by the recipe sequencer.
package maquina_pkg;

   typedef enum logic [2:0] {
      B_NINGUNA   = 3'd0,
      B_ESPRESSO  = 3'd1,
      B_AMERICANO = 3'd2,
      B_LATTE     = 3'd3,
      B_MOCHA     = 3'd4,
      B_CHOCOLATE = 3'd5
   } bebida_t;

   typedef enum logic [2:0] {
      F_IDLE   = 3'd0,
      F_AGUA   = 3'd1,
      F_CAFE   = 3'd2,
      F_LECHE  = 3'd3,
      F_CHOCO  = 3'd4,
      F_AZUCAR = 3'd5,
      F_LISTA  = 3'd6
   } fase_t;

   typedef logic [2:0] dur_t;

   typedef struct packed {
      dur_t agua;
      dur_t cafe;
      dur_t leche;
      dur_t choco;
   } receta_t;

   localparam dur_t DUR_AZUCAR = 3'd1;

   function automatic logic codigo_valido(logic [2:0] codigo);
      return (codigo >= 3'd1) && (codigo <= 3'd5);
   endfunction

   function automatic receta_t receta(bebida_t b);
      receta_t r;
      r = '0;
      case (b)
         B_ESPRESSO:  r = '{agua: 3'd2, cafe: 3'd3, leche: 3'd0, choco: 3'd0};
         B_AMERICANO: r = '{agua: 3'd4, cafe: 3'd2, leche: 3'd0, choco: 3'd0};
         B_LATTE:     r = '{agua: 3'd1, cafe: 3'd2, leche: 3'd3, choco: 3'd0};
         B_MOCHA:     r = '{agua: 3'd1, cafe: 3'd2, leche: 3'd2, choco: 3'd2};
         B_CHOCOLATE: r = '{agua: 3'd2, cafe: 3'd0, leche: 3'd2, choco: 3'd3};
         default:     r = '0;
      endcase
      return r;
   endfunction

   function automatic dur_t duracion(fase_t f, receta_t r, logic azucar);
      dur_t d;
      case (f)
         F_AGUA:   d = r.agua;
         F_CAFE:   d = r.cafe;
         F_LECHE:  d = r.leche;
         F_CHOCO:  d = r.choco;
         F_AZUCAR: d = azucar ? DUR_AZUCAR : 3'd0;
         default:  d = 3'd0;
      endcase
      return d;
   endfunction

   // Lowest-numbered phase after 'actual' with a non-zero duration; LISTA when none remain.
   function automatic fase_t siguiente_fase(fase_t actual, receta_t r, logic azucar);
      fase_t res;
      logic [2:0] idx;
      res = F_LISTA;
      for (int i = 5; i >= 1; i--) begin
         idx = i[2:0];
         if ((idx > actual) && (duracion(fase_t'(idx), r, azucar) != 3'd0)) begin
            res = fase_t'(idx);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/divisor_tick.sv
// Recipe-tick prescaler: one-cycle tick every CLK_DIV clocks, restarted from zero by clr.
module divisor_tick
   import maquina_pkg::*;
#(
   parameter int CLK_DIV = 50_000_000
) (
   input  logic clk_50Mhz,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == ULTIMO);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_50Mhz or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/secuenciador_bebidas.sv
// Recipe sequencer: latches one drink order and walks the valves agua..azucar
// for their programmed durations, then holds bebida_lista before returning to idle.
module secuenciador_bebidas
   import maquina_pkg::*;
#(
   parameter int CLK_DIV    = 50_000_000,
   parameter int DONE_TICKS = 2
) (
   input  logic       clk_50Mhz,
   input  logic       rst,
   input  logic       inicio,
   input  logic [2:0] bebida,
   input  logic       con_azucar,
   input  logic       abortar,
   output logic       agua,
   output logic       cafe,
   output logic       leche,
   output logic       choco,
   output logic       azucar,
   output logic       ocupado,
   output logic       bebida_lista,
   output logic       abortado,
   output logic [2:0] fase
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_LISTA = 2'd2
   } estado_t;

   localparam dur_t LISTA_TICKS = dur_t'((DONE_TICKS < 1) ? 1 : DONE_TICKS);

   estado_t estado_q, estado_d;
   fase_t   fase_q, fase_d;
   receta_t receta_q, receta_d;
   logic    azucar_q, azucar_d;
   dur_t    ticks_q, ticks_d;

   logic agua_q, agua_d;
   logic cafe_q, cafe_d;
   logic leche_q, leche_d;
   logic choco_q, choco_d;
   logic azucar_v_q, azucar_v_d;
   logic ocupado_q, ocupado_d;
   logic lista_q, lista_d;
   logic abortado_q, abortado_d;

   logic  tick;
   logic  fin_fase;
   logic  clr_div;
   fase_t fase_sig;

   assign fin_fase = tick && (ticks_q == 3'd1);
   assign clr_div  = (estado_q == S_IDLE) || abortar || fin_fase;
   assign fase_sig = siguiente_fase(fase_q, receta_q, azucar_q);

   divisor_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_divisor (
      .clk_50Mhz (clk_50Mhz),
      .rst       (rst),
      .clr       (clr_div),
      .tick      (tick)
   );

   // Next-state logic: abort wins over any phase advance in the same cycle.
   always_comb begin
      estado_d   = estado_q;
      fase_d     = fase_q;
      receta_d   = receta_q;
      azucar_d   = azucar_q;
      ticks_d    = ticks_q;
      abortado_d = 1'b0;

      case (estado_q)
         S_IDLE: begin
            if (inicio && codigo_valido(bebida)) begin
               receta_d = receta(bebida_t'(bebida));
               azucar_d = con_azucar;
               fase_d   = siguiente_fase(F_IDLE, receta_d, azucar_d);
               ticks_d  = duracion(fase_d, receta_d, azucar_d);
               estado_d = S_RUN;
            end
         end

         S_RUN: begin
            if (abortar) begin
               estado_d   = S_IDLE;
               fase_d     = F_IDLE;
               ticks_d    = 3'd0;
               abortado_d = 1'b1;
            end else if (tick) begin
               if (ticks_q == 3'd1) begin
                  fase_d = fase_sig;
                  if (fase_sig == F_LISTA) begin
                     estado_d = S_LISTA;
                     ticks_d  = LISTA_TICKS;
                  end else begin
                     ticks_d = duracion(fase_sig, receta_q, azucar_q);
                  end
               end else begin
                  ticks_d = ticks_q - 3'd1;
               end
            end
         end

         S_LISTA: begin
            if (abortar) begin
               estado_d   = S_IDLE;
               fase_d     = F_IDLE;
               ticks_d    = 3'd0;
               abortado_d = 1'b1;
            end else if (tick) begin
               if (ticks_q == 3'd1) begin
                  estado_d = S_IDLE;
                  fase_d   = F_IDLE;
                  ticks_d  = 3'd0;
               end else begin
                  ticks_d = ticks_q - 3'd1;
               end
            end
         end

         default: begin
            estado_d = S_IDLE;
            fase_d   = F_IDLE;
            ticks_d  = 3'd0;
         end
      endcase

      agua_d     = (fase_d == F_AGUA);
      cafe_d     = (fase_d == F_CAFE);
      leche_d    = (fase_d == F_LECHE);
      choco_d    = (fase_d == F_CHOCO);
      azucar_v_d = (fase_d == F_AZUCAR);
      lista_d    = (fase_d == F_LISTA);
      ocupado_d  = (estado_d != S_IDLE);
   end

   always_ff @(posedge clk_50Mhz or negedge rst) begin
      if (!rst) begin
         estado_q   <= S_IDLE;
         fase_q     <= F_IDLE;
         receta_q   <= '0;
         azucar_q   <= 1'b0;
         ticks_q    <= 3'd0;
         agua_q     <= 1'b0;
         cafe_q     <= 1'b0;
         leche_q    <= 1'b0;
         choco_q    <= 1'b0;
         azucar_v_q <= 1'b0;
         ocupado_q  <= 1'b0;
         lista_q    <= 1'b0;
         abortado_q <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         fase_q     <= fase_d;
         receta_q   <= receta_d;
         azucar_q   <= azucar_d;
         ticks_q    <= ticks_d;
         agua_q     <= agua_d;
         cafe_q     <= cafe_d;
         leche_q    <= leche_d;
         choco_q    <= choco_d;
         azucar_v_q <= azucar_v_d;
         ocupado_q  <= ocupado_d;
         lista_q    <= lista_d;
         abortado_q <= abortado_d;
      end
   end

   assign agua         = agua_q;
   assign cafe         = cafe_q;
   assign leche        = leche_q;
   assign choco        = choco_q;
   assign azucar       = azucar_v_q;
   assign ocupado      = ocupado_q;
   assign bebida_lista = lista_q;
   assign abortado     = abortado_q;
   assign fase         = fase_q;

endmodule

// File: tb/tb_secuenciador_bebidas.sv
// Directed bench for secuenciador_bebidas with CLK_DIV=4: records outputs per cycle
// after each order and compares valve windows against hand-computed cycle numbers.
module tb_secuenciador_bebidas;

   logic       clk_50Mhz;
   logic       rst;
   logic       inicio;
   logic [2:0] bebida;
   logic       con_azucar;
   logic       abortar;
   logic       agua, cafe, leche, choco, azucar;
   logic       ocupado, bebida_lista, abortado;
   logic [2:0] fase;

   int checks;
   int errors;
   int n_rec;
   int onehot_err;

   // bit 0 agua, 1 cafe, 2 leche, 3 choco, 4 azucar, 5 lista, 6 ocupado, 7 abortado
   logic [7:0] rec    [0:127];
   logic [2:0] fase_a [0:127];

   secuenciador_bebidas #(
      .CLK_DIV    (4),
      .DONE_TICKS (2)
   ) dut (
      .clk_50Mhz    (clk_50Mhz),
      .rst          (rst),
      .inicio       (inicio),
      .bebida       (bebida),
      .con_azucar   (con_azucar),
      .abortar      (abortar),
      .agua         (agua),
      .cafe         (cafe),
      .leche        (leche),
      .choco        (choco),
      .azucar       (azucar),
      .ocupado      (ocupado),
      .bebida_lista (bebida_lista),
      .abortado     (abortado),
      .fase         (fase)
   );

   initial clk_50Mhz = 1'b0;
   always #5 clk_50Mhz = ~clk_50Mhz;

   function automatic int first_hi(int b);
      for (int c = 1; c <= n_rec; c++) if (rec[c][b]) return c;
      return -1;
   endfunction

   function automatic int last_hi(int b);
      int l;
      l = -1;
      for (int c = 1; c <= n_rec; c++) if (rec[c][b]) l = c;
      return l;
   endfunction

   function automatic int count_hi(int b);
      int n;
      n = 0;
      for (int c = 1; c <= n_rec; c++) if (rec[c][b]) n++;
      return n;
   endfunction

   task automatic applyStimulus(input logic [2:0] code, input logic az);
      @(negedge clk_50Mhz);
      bebida     = code;
      con_azucar = az;
      inicio     = 1'b1;
   endtask

   // Samples cycle c at its negedge, then applies that cycle's scripted input changes.
   task automatic correr(input int n, input bit hold, input int abort_c,
                         input int ini_c, input logic [2:0] ini_code);
      int unos;
      n_rec      = n;
      onehot_err = 0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk_50Mhz);
         rec[c]    = {abortado, ocupado, bebida_lista, azucar, choco, leche, cafe, agua};
         fase_a[c] = fase;
         unos = 0;
         for (int b = 0; b < 5; b++) if (rec[c][b]) unos++;
         if (unos > 1) onehot_err++;
         if (!hold) inicio = 1'b0;
         abortar = (c == abort_c);
         if (c == ini_c) begin
            inicio = 1'b1;
            bebida = ini_code;
         end
      end
      abortar = 1'b0;
      if (!hold) inicio = 1'b0;
   endtask

   task automatic esperar_idle();
      int k;
      k = 0;
      inicio  = 1'b0;
      abortar = 1'b0;
      @(negedge clk_50Mhz);
      while (ocupado && k < 300) begin
         @(negedge clk_50Mhz);
         k++;
      end
      if (k >= 300) begin
         checks++;
         errors++;
         $display("[TB] FAIL idle_timeout got ocupado=%0b want 0", ocupado);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++;
      if ({agua, cafe, leche, choco, azucar} !== 5'b0) begin
         errors++; $display("[TB] FAIL reset_valves got %b want 00000", {agua, cafe, leche, choco, azucar});
      end
      checks++;
      if ({ocupado, bebida_lista, abortado} !== 3'b0) begin
         errors++; $display("[TB] FAIL reset_status got %b want 000", {ocupado, bebida_lista, abortado});
      end
      checks++;
      if (fase !== 3'd0) begin
         errors++; $display("[TB] FAIL reset_fase got %0d want 0", fase);
      end
      @(negedge clk_50Mhz);
      @(negedge clk_50Mhz);
      rst = 1'b1;
      @(negedge clk_50Mhz);
   endtask

   task automatic test_espresso();
      applyStimulus(3'd1, 1'b0);
      correr(32, 1'b0, -1, -1, 3'd0);
      checks++;
      if (first_hi(0) !== 1 || last_hi(0) !== 8 || count_hi(0) !== 8) begin
         errors++; $display("[TB] FAIL esp_agua got %0d..%0d want 1..8", first_hi(0), last_hi(0));
      end
      checks++;
      if (first_hi(1) !== 9 || last_hi(1) !== 20 || count_hi(1) !== 12) begin
         errors++; $display("[TB] FAIL esp_cafe got %0d..%0d want 9..20", first_hi(1), last_hi(1));
      end
      checks++;
      if (first_hi(5) !== 21 || last_hi(5) !== 28 || count_hi(5) !== 8) begin
         errors++; $display("[TB] FAIL esp_lista got %0d..%0d want 21..28", first_hi(5), last_hi(5));
      end
      checks++;
      if (first_hi(6) !== 1 || last_hi(6) !== 28 || count_hi(6) !== 28) begin
         errors++; $display("[TB] FAIL esp_ocupado got %0d..%0d want 1..28", first_hi(6), last_hi(6));
      end
      checks++;
      if (fase_a[1] !== 3'd1 || fase_a[9] !== 3'd2 || fase_a[21] !== 3'd6 || fase_a[29] !== 3'd0) begin
         errors++; $display("[TB] FAIL esp_fase got %0d %0d %0d %0d want 1 2 6 0",
                            fase_a[1], fase_a[9], fase_a[21], fase_a[29]);
      end
      checks++;
      if (count_hi(2) + count_hi(3) + count_hi(4) + count_hi(7) !== 0) begin
         errors++; $display("[TB] FAIL esp_extra got %0d want 0", count_hi(2) + count_hi(3) + count_hi(4) + count_hi(7));
      end
      esperar_idle();
   endtask

   task automatic test_chocolate_azucar();
      applyStimulus(3'd5, 1'b1);
      correr(44, 1'b0, -1, -1, 3'd0);
      checks++;
      if (first_hi(0) !== 1 || last_hi(0) !== 8) begin
         errors++; $display("[TB] FAIL choc_agua got %0d..%0d want 1..8", first_hi(0), last_hi(0));
      end
      checks++;
      if (count_hi(1) !== 0) begin
         errors++; $display("[TB] FAIL choc_cafe got %0d want 0", count_hi(1));
      end
      checks++;
      if (first_hi(2) !== 9 || last_hi(2) !== 16) begin
         errors++; $display("[TB] FAIL choc_leche got %0d..%0d want 9..16", first_hi(2), last_hi(2));
      end
      checks++;
      if (first_hi(3) !== 17 || count_hi(3) !== 12) begin
         errors++; $display("[TB] FAIL choc_choco got %0d/%0d want 17/12", first_hi(3), count_hi(3));
      end
      checks++;
      if (first_hi(4) !== 29 || count_hi(4) !== 4) begin
         errors++; $display("[TB] FAIL choc_azucar got %0d/%0d want 29/4", first_hi(4), count_hi(4));
      end
      checks++;
      if (first_hi(5) !== 33 || last_hi(6) !== 40) begin
         errors++; $display("[TB] FAIL choc_lista got %0d/%0d want 33/40", first_hi(5), last_hi(6));
      end
      checks++;
      if (onehot_err !== 0) begin
         errors++; $display("[TB] FAIL choc_onehot got %0d want 0", onehot_err);
      end
      esperar_idle();
   endtask

   task automatic test_abort_mocha();
      applyStimulus(3'd4, 1'b0);
      correr(30, 1'b0, 15, -1, 3'd0);
      checks++;
      if (first_hi(2) !== 13 || count_hi(2) !== 3) begin
         errors++; $display("[TB] FAIL abort_leche got %0d/%0d want 13/3", first_hi(2), count_hi(2));
      end
      checks++;
      if (rec[16][4:0] !== 5'b0 || fase_a[16] !== 3'd0 || rec[16][6] !== 1'b0) begin
         errors++; $display("[TB] FAIL abort_clear got %b fase %0d want 0000000 fase 0", rec[16][6:0], fase_a[16]);
      end
      checks++;
      if (first_hi(7) !== 16 || count_hi(7) !== 1) begin
         errors++; $display("[TB] FAIL abort_pulse got %0d/%0d want 16/1", first_hi(7), count_hi(7));
      end
      checks++;
      if (count_hi(5) !== 0 || count_hi(3) !== 0) begin
         errors++; $display("[TB] FAIL abort_lista got %0d want 0", count_hi(5) + count_hi(3));
      end
      esperar_idle();
   endtask

   task automatic test_invalid_reinicio();
      applyStimulus(3'd6, 1'b0);
      correr(4, 1'b0, -1, -1, 3'd0);
      checks++;
      if (count_hi(6) !== 0 || count_hi(0) !== 0 || fase_a[2] !== 3'd0) begin
         errors++; $display("[TB] FAIL invalid_code got %0d want 0", count_hi(6) + count_hi(0));
      end
      applyStimulus(3'd3, 1'b0);
      correr(36, 1'b0, -1, 6, 3'd1);
      checks++;
      if (first_hi(0) !== 1 || count_hi(0) !== 4) begin
         errors++; $display("[TB] FAIL latte_agua got %0d/%0d want 1/4", first_hi(0), count_hi(0));
      end
      checks++;
      if (first_hi(1) !== 5 || count_hi(1) !== 8) begin
         errors++; $display("[TB] FAIL latte_cafe got %0d/%0d want 5/8", first_hi(1), count_hi(1));
      end
      checks++;
      if (first_hi(2) !== 13 || count_hi(2) !== 12) begin
         errors++; $display("[TB] FAIL latte_leche got %0d/%0d want 13/12", first_hi(2), count_hi(2));
      end
      checks++;
      if (last_hi(6) !== 32 || rec[33][6] !== 1'b0) begin
         errors++; $display("[TB] FAIL latte_ocupado got %0d want 32", last_hi(6));
      end
      esperar_idle();
   endtask

   task automatic checkOutput_reset_mid();
      applyStimulus(3'd2, 1'b0);
      correr(20, 1'b0, -1, -1, 3'd0);
      checks++;
      if (rec[20][1] !== 1'b1 || last_hi(0) !== 16) begin
         errors++; $display("[TB] FAIL amer_pre got cafe=%0b agua_last=%0d want 1/16", rec[20][1], last_hi(0));
      end
      @(negedge clk_50Mhz);
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({agua, cafe, leche, choco, azucar, ocupado, bebida_lista, abortado} !== 8'b0 || fase !== 3'd0) begin
         errors++; $display("[TB] FAIL async_reset got %b fase %0d want 0",
                            {agua, cafe, leche, choco, azucar, ocupado, bebida_lista, abortado}, fase);
      end
      @(negedge clk_50Mhz);
      rst = 1'b1;
      applyStimulus(3'd1, 1'b0);
      correr(32, 1'b0, -1, -1, 3'd0);
      checks++;
      if (first_hi(0) !== 1 || last_hi(0) !== 8 || first_hi(1) !== 9 || last_hi(1) !== 20) begin
         errors++; $display("[TB] FAIL post_reset_esp got %0d..%0d %0d..%0d want 1..8 9..20",
                            first_hi(0), last_hi(0), first_hi(1), last_hi(1));
      end
      checks++;
      if (first_hi(5) !== 21 || last_hi(6) !== 28) begin
         errors++; $display("[TB] FAIL post_reset_lista got %0d/%0d want 21/28", first_hi(5), last_hi(6));
      end
      esperar_idle();
   endtask

   task automatic test_back_to_back();
      applyStimulus(3'd2, 1'b0);
      correr(60, 1'b1, -1, -1, 3'd0);
      checks++;
      if (rec[32][6] !== 1'b1 || rec[33][6] !== 1'b0 || fase_a[33] !== 3'd0) begin
         errors++; $display("[TB] FAIL b2b_gap got %0b%0b fase %0d want 10 fase 0", rec[32][6], rec[33][6], fase_a[33]);
      end
      checks++;
      if (rec[34][0] !== 1'b1 || rec[34][6] !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_start got %b want agua+ocupado", rec[34]);
      end
      checks++;
      if (count_hi(0) !== 32 || last_hi(0) !== 49 || rec[50][1] !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_agua got %0d/%0d want 32/49", count_hi(0), last_hi(0));
      end
      esperar_idle();
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      n_rec      = 0;
      onehot_err = 0;
      inicio     = 1'b0;
      bebida     = 3'd0;
      con_azucar = 1'b0;
      abortar    = 1'b0;
      test_reset();
      test_espresso();
      test_chocolate_azucar();
      test_abort_mocha();
      test_invalid_reinicio();
      checkOutput_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
